// File: rtl/rf_frame_tx.sv
// Transmit side of the rfin/sh_en framing link: accepts a parallel word and
// emits a start strobe, an MSB-first payload framed by sh_en, then a guard gap.
module rf_frame_tx #(
    parameter int DATA_W    = 8,
    parameter int START_LEN = 1,
    parameter int GAP_LEN   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              abort,
    output logic              rfout,
    output logic              sh_en,
    output logic              sdata,
    output logic              busy,
    output logic              done
);

    localparam int MAX_SD  = (START_LEN > DATA_W) ? START_LEN : DATA_W;
    localparam int MAX_LEN = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_SHIFT = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   shreg_q;
    logic                abort_pend_q;
    logic                tx_ready_q;
    logic                rfout_q;
    logic                sh_en_q;
    logic                sdata_q;
    logic                busy_q;
    logic                done_q;

    logic                abort_pend_d;
    logic [DATA_W-1:0]   shreg_d;

    assign abort_pend_d = abort_pend_q | abort;
    assign shreg_d      = {shreg_q[DATA_W-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            abort_pend_q <= 1'b0;
            tx_ready_q   <= 1'b0;
            rfout_q      <= 1'b0;
            sh_en_q      <= 1'b0;
            sdata_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_ready_q <= 1'b1;
                    if (tx_valid && tx_ready_q) begin
                        shreg_q    <= tx_data;
                        state_q    <= S_START;
                        cnt_q      <= CNT_W'(START_LEN - 1);
                        tx_ready_q <= 1'b0;
                        rfout_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                S_START: begin
                    // An abort here is only remembered; one payload bit still goes out
                    // so the receiver always sees sh_en fall.
                    abort_pend_q <= abort_pend_d;
                    if (cnt_q == '0) begin
                        state_q <= S_SHIFT;
                        cnt_q   <= CNT_W'(DATA_W - 1);
                        rfout_q <= 1'b0;
                        sh_en_q <= 1'b1;
                        sdata_q <= shreg_q[DATA_W-1];
                        shreg_q <= shreg_d;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_SHIFT: begin
                    abort_pend_q <= abort_pend_d;
                    if (cnt_q == '0 || abort_pend_d) begin
                        state_q <= S_GAP;
                        cnt_q   <= CNT_W'(GAP_LEN - 1);
                        sh_en_q <= 1'b0;
                        sdata_q <= 1'b0;
                        done_q  <= (GAP_LEN == 1) && !abort_pend_d;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                        sdata_q <= shreg_q[DATA_W-1];
                        shreg_q <= shreg_d;
                    end
                end
                S_GAP: begin
                    if (cnt_q == '0) begin
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                        tx_ready_q   <= 1'b1;
                        abort_pend_q <= 1'b0;
                    end else begin
                        cnt_q  <= cnt_q - CNT_W'(1);
                        done_q <= (cnt_q == CNT_W'(1)) && !abort_pend_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign rfout    = rfout_q;
    assign sh_en    = sh_en_q;
    assign sdata    = sdata_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
